wb_port_arbiter: RTL and testbench
==================================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter NR_REQ, default 3, number of fixed-latency FUs sharing one scoreboard writeback port.
REQ-002 SHALL have parameter DATA_W, default 64, writeback data width (XLEN).
REQ-003 SHALL have parameter TID_W, default 3, transaction-ID width (TRANS_ID_BITS).
REQ-004 SHALL have port clk_i  in  1  clock; one clock, all state on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush_i  in  1  pipeline flush, discards all held results.
REQ-007 SHALL have port req_valid_i  in  NR_REQ  per-FU result valid.
REQ-008 SHALL have port req_ready_o  out  NR_REQ  per-FU result accepted.
REQ-009 SHALL have port req_tid_i  in  NR_REQ x TID_W  per-FU transaction ID.
REQ-010 SHALL have port req_data_i  in  NR_REQ x DATA_W  per-FU result data.
REQ-011 SHALL have port req_ex_i  in  NR_REQ  per-FU exception-valid flag.
REQ-012 SHALL have port wb_valid_o  out  1  writeback valid to scoreboard.
REQ-013 SHALL have port wb_tid_o  out  TID_W  writeback transaction ID.
REQ-014 SHALL have port wb_data_o  out  DATA_W  writeback data.
REQ-015 SHALL have port wb_ex_o  out  1  writeback exception flag.
REQ-016 SHALL have port conflict_cnt_o  out  16  saturating count of conflict cycles.

Function
REQ-017 SHALL hold, per requester i, one entry {hold_v[i], tid, data, ex}.
REQ-018 SHALL capture requester i into its entry at a rising edge where req_valid_i[i] and req_ready_o[i] are both high.
REQ-019 SHALL drive req_ready_o[i] = !flush_i & (!hold_v[i] | gnt[i]), independent of req_valid_i.
REQ-020 SHALL compute one-hot gnt as the first i with hold_v[i] set, searching from rr_ptr upward and wrapping modulo NR_REQ; gnt is all-zero when no hold_v is set or flush_i is high.
REQ-021 SHALL drive wb_valid_o = |gnt, and drive wb_tid_o/wb_data_o/wb_ex_o from the granted entry combinationally; these are zero when wb_valid_o is low.
REQ-022 SHALL have latency of exactly one cycle from capture to wb_valid_o when uncontended; there is no scoreboard backpressure, so a granted entry always retires in its grant cycle.
REQ-023 SHALL clear hold_v[i] at the edge ending a grant cycle unless a new capture into i occurs at that same edge, in which case the new result replaces it (hold_v stays 1).
REQ-024 SHALL update rr_ptr to (granted index + 1) mod NR_REQ on each grant, and hold rr_ptr otherwise.
REQ-025 SHALL, while flush_i is high, clear all hold_v at the next edge, accept nothing, grant nothing, and leave rr_ptr unchanged.
REQ-026 SHALL increment conflict_cnt_o by 1 in each non-flush cycle with two or more hold_v set, saturating at 16'hFFFF, never wrapping.
REQ-027 SHALL guarantee that a held entry is granted within NR_REQ cycles of capture (starvation-free).
REQ-028 SHALL keep ex-flagged results in normal arbitration order, with no priority boost.

Reset
REQ-029 SHALL, while rst_i is high, force hold_v=0, rr_ptr=0, conflict_cnt_o=0, wb_valid_o=0, and req_ready_o=0, asynchronously.
REQ-030 SHALL have req_ready_o all-ones in the first cycle after rst_i deasserts, with flush_i low.
REQ-031 SHALL have a reset asserted mid-operation drop any held results, so that no wb_valid_o occurs for them afterwards.

Verification
REQ-032 SHALL cover single requester: req_valid_i=3'b010, tid=5, data=0xDEAD in cycle 0 -> wb_valid_o=1, wb_tid_o=5, wb_data_o=0xDEAD in cycle 1 only; rr_ptr becomes 2.
REQ-033 SHALL cover three-way conflict: all three capture in cycle 0, rr_ptr=0 -> grants 0,1,2 in cycles 1,2,3; conflict_cnt_o=2; req_ready_o[2]=0 in cycles 1-2.
REQ-034 SHALL cover back-to-back throughput: requester 0 valid every cycle with no contention -> wb_valid_o high every cycle from cycle 1, with tids in order and no drops.
REQ-035 SHALL cover flush: entries held for 1 and 2, flush_i=1 in cycle 1 -> wb_valid_o=0 in cycle 1, no writeback of either later, rr_ptr unchanged.
REQ-036 SHALL cover reset mid-operation: rst_i pulses while hold_v=3'b111 -> all outputs 0 immediately, and no wb_valid_o after release until new captures.
REQ-037 SHALL cover saturation: force conflict for 70000 cycles -> conflict_cnt_o holds at 0xFFFF.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that merges fixed-latency FU results onto one
// scoreboard writeback port, with one holding entry per requester.
module wb_port_arbiter #(
    parameter int NR_REQ = 3,
    parameter int DATA_W = 64,
    parameter int TID_W  = 3
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic [NR_REQ-1:0]              req_valid_i,
    output logic [NR_REQ-1:0]              req_ready_o,
    input  logic [NR_REQ-1:0][TID_W-1:0]   req_tid_i,
    input  logic [NR_REQ-1:0][DATA_W-1:0]  req_data_i,
    input  logic [NR_REQ-1:0]              req_ex_i,
    output logic                           wb_valid_o,
    output logic [TID_W-1:0]               wb_tid_o,
    output logic [DATA_W-1:0]              wb_data_o,
    output logic                           wb_ex_o,
    output logic [15:0]                    conflict_cnt_o
);

    localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

    logic [NR_REQ-1:0]             hold_v;
    logic [NR_REQ-1:0][TID_W-1:0]  hold_tid;
    logic [NR_REQ-1:0][DATA_W-1:0] hold_data;
    logic [NR_REQ-1:0]             hold_ex;
    logic [NR_REQ-1:0]             gnt;
    logic [NR_REQ-1:0]             cap;
    logic [PW-1:0]                 rr_ptr;
    logic [PW-1:0]                 gnt_idx;
    logic                          found;
    logic                          seen;
    logic                          multi;

    // Search starts at rr_ptr and wraps, so every held entry is
    // reached within NR_REQ grants.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NR_REQ; k++) begin
            if (!found && hold_v[(int'(rr_ptr) + k) % NR_REQ]) begin
                found   = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NR_REQ);
            end
        end
        if (found && !flush_i) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NR_REQ; i++) begin
            if (hold_v[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
    end

    assign req_ready_o = {NR_REQ{!rst_i && !flush_i}} & (~hold_v | gnt);
    assign cap         = req_valid_i & req_ready_o;

    assign wb_valid_o = |gnt;
    assign wb_tid_o   = wb_valid_o ? hold_tid[gnt_idx]  : '0;
    assign wb_data_o  = wb_valid_o ? hold_data[gnt_idx] : '0;
    assign wb_ex_o    = wb_valid_o ? hold_ex[gnt_idx]   : 1'b0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_v    <= '0;
            hold_tid  <= '0;
            hold_data <= '0;
            hold_ex   <= '0;
        end else begin
            for (int i = 0; i < NR_REQ; i++) begin
                if (flush_i) begin
                    hold_v[i] <= 1'b0;
                end else if (cap[i]) begin
                    hold_v[i]    <= 1'b1;
                    hold_tid[i]  <= req_tid_i[i];
                    hold_data[i] <= req_data_i[i];
                    hold_ex[i]   <= req_ex_i[i];
                end else if (gnt[i]) begin
                    hold_v[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= (gnt_idx == PW'(NR_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_cnt_o <= '0;
        end else if (!flush_i && multi && conflict_cnt_o != 16'hFFFF) begin
            conflict_cnt_o <= conflict_cnt_o + 16'd1;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed-vector bench for wb_port_arbiter with hand-computed expectations.
module tb_wb_port_arbiter;

    logic              clk_i;
    logic              rst_i;
    logic              flush_i;
    logic [2:0]        req_valid_i;
    logic [2:0]        req_ready_o;
    logic [2:0][2:0]   req_tid_i;
    logic [2:0][63:0]  req_data_i;
    logic [2:0]        req_ex_i;
    logic              wb_valid_o;
    logic [2:0]        wb_tid_o;
    logic [63:0]       wb_data_o;
    logic              wb_ex_o;
    logic [15:0]       conflict_cnt_o;

    int tests;
    int fails;
    logic wb_seen;

    wb_port_arbiter #(.NR_REQ(3), .DATA_W(64), .TID_W(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_tid_i      (req_tid_i),
        .req_data_i     (req_data_i),
        .req_ex_i       (req_ex_i),
        .wb_valid_o     (wb_valid_o),
        .wb_tid_o       (wb_tid_o),
        .wb_data_o      (wb_data_o),
        .wb_ex_o        (wb_ex_o),
        .conflict_cnt_o (conflict_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb_chk(input string tag, input logic v,
                          input logic [2:0] tid, input logic ex);
        chk({tag, ".v"}, 64'(wb_valid_o), 64'(v));
        chk({tag, ".tid"}, 64'(wb_tid_o), 64'(tid));
        chk({tag, ".ex"}, 64'(wb_ex_o), 64'(ex));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        req_valid_i = '0;
        req_tid_i   = '0;
        req_data_i  = '0;
        req_ex_i    = '0;
        #12;
        chk("rst.wbv", 64'(wb_valid_o), 64'd0);
        chk("rst.rdy", 64'(req_ready_o), 64'd0);
        chk("rst.cnt", 64'(conflict_cnt_o), 64'd0);
        rst_i = 1'b0;
        #1;
        chk("post_rst.rdy", 64'(req_ready_o), 64'b111);
        step();

        // single requester 1 -> rr_ptr becomes 2
        req_valid_i   = 3'b010;
        req_tid_i[1]  = 3'd5;
        req_data_i[1] = 64'hDEAD;
        step();
        req_valid_i = '0;
        #1;
        wb_chk("single.c1", 1'b1, 3'd5, 1'b0);
        chk("single.data", wb_data_o, 64'hDEAD);
        step();
        wb_chk("single.c2", 1'b0, 3'd0, 1'b0);

        // rr_ptr=2: all three -> grants 2,0,1
        req_valid_i = 3'b111;
        req_tid_i   = {3'd3, 3'd2, 3'd1};
        req_ex_i    = 3'b001;
        step();
        req_valid_i = '0;
        req_ex_i    = '0;
        #1;
        wb_chk("rr2.c1", 1'b1, 3'd3, 1'b0);
        chk("rr2.rdy1", 64'(req_ready_o), 64'b100);
        step();
        wb_chk("rr2.c2", 1'b1, 3'd1, 1'b1);
        chk("rr2.rdy2", 64'(req_ready_o), 64'b101);
        step();
        wb_chk("rr2.c3", 1'b1, 3'd2, 1'b0);
        step();
        wb_chk("rr2.c4", 1'b0, 3'd0, 1'b0);
        chk("rr2.cnt", 64'(conflict_cnt_o), 64'd2);

        // requester 2 alone -> rr_ptr=0, then 3-way grants 0,1,2
        req_valid_i  = 3'b100;
        req_tid_i[2] = 3'd7;
        step();
        req_valid_i = '0;
        #1;
        wb_chk("r2.c1", 1'b1, 3'd7, 1'b0);
        step();
        req_valid_i = 3'b111;
        req_tid_i   = {3'd6, 3'd5, 3'd4};
        step();
        req_valid_i = '0;
        #1;
        wb_chk("rr0.c1", 1'b1, 3'd4, 1'b0);
        chk("rr0.rdy2_c1", 64'(req_ready_o[2]), 64'd0);
        step();
        wb_chk("rr0.c2", 1'b1, 3'd5, 1'b0);
        chk("rr0.rdy2_c2", 64'(req_ready_o[2]), 64'd0);
        step();
        wb_chk("rr0.c3", 1'b1, 3'd6, 1'b0);
        step();
        chk("rr0.cnt", 64'(conflict_cnt_o), 64'd4);

        // back-to-back on requester 0
        req_valid_i = 3'b001;
        req_tid_i   = '0;
        step();
        for (int k = 1; k < 8; k++) begin
            req_tid_i[0] = 3'(k);
            #1;
            wb_chk($sformatf("b2b.%0d", k), 1'b1, 3'(k - 1), 1'b0);
            step();
        end
        req_valid_i = '0;
        #1;
        wb_chk("b2b.last", 1'b1, 3'd7, 1'b0);
        step();
        wb_chk("b2b.idle", 1'b0, 3'd0, 1'b0);
        chk("b2b.cnt", 64'(conflict_cnt_o), 64'd4);

        // rr_ptr=1; flush entries 1 and 2
        req_valid_i = 3'b110;
        req_tid_i   = {3'd2, 3'd1, 3'd0};
        step();
        req_valid_i = '0;
        flush_i     = 1'b1;
        #1;
        wb_chk("flush.c1", 1'b0, 3'd0, 1'b0);
        chk("flush.rdy", 64'(req_ready_o), 64'd0);
        step();
        flush_i = 1'b0;
        wb_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (wb_valid_o) wb_seen = 1'b1;
            step();
        end
        chk("flush.no_wb", 64'(wb_seen), 64'd0);
        chk("flush.cnt", 64'(conflict_cnt_o), 64'd4);
        req_valid_i = 3'b111;
        req_tid_i   = {3'd3, 3'd2, 3'd1};
        step();
        req_valid_i = '0;
        #1;
        wb_chk("flush.rr1", 1'b1, 3'd2, 1'b0);
        step();
        wb_chk("flush.rr2", 1'b1, 3'd3, 1'b0);
        step();
        wb_chk("flush.rr0", 1'b1, 3'd1, 1'b0);
        step();
        chk("flush.cnt2", 64'(conflict_cnt_o), 64'd6);

        // reset while all three held
        req_valid_i = 3'b111;
        step();
        req_valid_i = '0;
        #1;
        chk("mrst.pre", 64'(wb_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("mrst.wbv", 64'(wb_valid_o), 64'd0);
        chk("mrst.rdy", 64'(req_ready_o), 64'd0);
        chk("mrst.cnt", 64'(conflict_cnt_o), 64'd0);
        chk("mrst.tid", 64'(wb_tid_o), 64'd0);
        #1;
        rst_i   = 1'b0;
        wb_seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (wb_valid_o) wb_seen = 1'b1;
        end
        chk("mrst.no_wb", 64'(wb_seen), 64'd0);

        // continuous two-way conflict saturates the counter
        req_valid_i = 3'b011;
        req_tid_i   = {3'd0, 3'd2, 3'd1};
        step();
        step();
        step();
        chk("sat.early", 64'(conflict_cnt_o), 64'd2);
        repeat (70000) @(posedge clk_i);
        #1;
        chk("sat.cnt", 64'(conflict_cnt_o), 64'hFFFF);
        step();
        chk("sat.hold", 64'(conflict_cnt_o), 64'hFFFF);
        chk("sat.wbv", 64'(wb_valid_o), 64'd1);
        req_valid_i = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
